pulse_stretch: RTL and testbench

Converts single-cycle trigger pulses (e.g. debounced button edges) into a fixed-width output level of HIGH_CYCLES clocks, followed by a mandatory low gap of GAP_CYCLES clocks. It sits between edge-producing input conditioning and slow consumers such as LEDs, external strobes, or handshake lines that need a guaranteed minimum high time and minimum separation. It also reports triggers it cannot honour.

---
 rtl/pulse_stretch_pkg.sv | 10 +
 rtl/pulse_stretch_counter.sv | 19 +
 rtl/pulse_stretch.sv | 84 ++++++++
 tb/tb_pulse_stretch.sv | 97 +++++++++
 4 files changed

// File: rtl/pulse_stretch_pkg.sv
// pulse_stretch_pkg: shared state enum, counter width and parameter legality helpers
package pulse_stretch_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;
  function automatic int cnt_width(input int h, input int g);
    return $clog2(((h > g) ? h : g) + 1);
  endfunction
  function automatic bit params_ok(input int h, input int g);
    return (h >= 1) && (g >= 0);
  endfunction
endpackage

// File: rtl/pulse_stretch_counter.sv
// stretch_counter: loadable down-counter that saturates at zero
module stretch_counter #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge i_clk) begin
    if (i_rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/pulse_stretch.sv
// pulse_stretch: trigger-to-fixed-width pulse with forced gap; PULSE_STRETCH_RETRIGGER_EN lets HIGH reload
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iTrig,
  output logic oQ,
  output logic oBusy,
  output logic oDropped
);
  localparam int CNT_W = cnt_width(HIGH_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] HIGH_LD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  if (!params_ok(HIGH_CYCLES, GAP_CYCLES)) begin : g_bad_params
    $error("pulse_stretch: HIGH_CYCLES must be >= 1 and GAP_CYCLES >= 0");
  end
  state_t           r_state, w_next;
  logic             r_q, r_busy, r_drop;
  logic             w_load, w_dec, w_drop, w_zero;
  logic [CNT_W-1:0] w_load_val;
  stretch_counter #(.W(CNT_W)) u_cnt (
    .i_clk      (iClk),
    .i_rst      (iRst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = HIGH_LD;
    w_dec      = 1'b0;
    w_drop     = 1'b0;
    case (r_state)
      IDLE: begin
        w_next = iTrig ? HIGH : IDLE;
        w_load = iTrig;
      end
      HIGH: begin
`ifndef PULSE_STRETCH_RETRIGGER_EN
        w_drop = iTrig;
`endif
`ifdef PULSE_STRETCH_RETRIGGER_EN
        if (iTrig) w_load = 1'b1;
        else
`endif
        if (!w_zero) w_dec = 1'b1;
        else if (GAP_CYCLES > 0) begin
          w_next     = GAP;
          w_load     = 1'b1;
          w_load_val = GAP_LD;
        end else w_next = IDLE;
      end
      GAP: begin
        w_drop = iTrig;
        w_dec  = !w_zero;
        w_next = w_zero ? IDLE : GAP;
      end
      default: w_next = IDLE;
    endcase
  end
  // outputs decode the next state so they line up with it
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= IDLE;
      r_q     <= 1'b0;
      r_busy  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_q     <= (w_next == HIGH);
      r_busy  <= (w_next != IDLE);
      r_drop  <= w_drop;
    end
  end
  assign oQ       = r_q;
  assign oBusy    = r_busy;
  assign oDropped = r_drop;
endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch: directed plus random triggers checked against a time-window model
module tb_pulse_stretch;
  localparam int H = 4;
  localparam int G0 = 2;
  localparam int G1 = 0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trig = 1'b0;
  logic q0, busy0, drop0, q1, busy1, drop1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   hi_end[2];
  int   busy_end[2];
  bit   drop_exp[2];
  int   gap[2];
  always #5 clk = ~clk;
  pulse_stretch #(.HIGH_CYCLES(H), .GAP_CYCLES(G0)) dut0 (
    .iClk(clk), .iRst(rst), .iTrig(trig), .oQ(q0), .oBusy(busy0), .oDropped(drop0)
  );
  pulse_stretch #(.HIGH_CYCLES(H), .GAP_CYCLES(G1)) dut1 (
    .iClk(clk), .iRst(rst), .iTrig(trig), .oQ(q1), .oBusy(busy1), .oDropped(drop1)
  );
  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask
  // a pulse is a window of absolute cycles: high through hi_end, busy through busy_end
  task automatic model(input int d, input bit r, input bit t, input int n);
    drop_exp[d] = 1'b0;
    if (r) begin
      hi_end[d]   = n;
      busy_end[d] = n;
    end else if (n > busy_end[d]) begin
      if (t) begin
        hi_end[d]   = n + H;
        busy_end[d] = n + H + gap[d];
      end
    end else if (n <= hi_end[d]) begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
      if (t) begin
        hi_end[d]   = n + H;
        busy_end[d] = n + H + gap[d];
      end
`else
      drop_exp[d] = t;
`endif
    end else drop_exp[d] = t;
  endtask
  task automatic step(input bit r, input bit t);
    rst  = r;
    trig = t;
    for (int d = 0; d < 2; d++) model(d, r, t, cyc);
    @(posedge clk);
    #1;
    cyc++;
    check("g2_q",    q0,    cyc <= hi_end[0]);
    check("g2_busy", busy0, cyc <= busy_end[0]);
    check("g2_drop", drop0, drop_exp[0]);
    check("g0_q",    q1,    cyc <= hi_end[1]);
    check("g0_busy", busy1, cyc <= busy_end[1]);
    check("g0_drop", drop1, drop_exp[1]);
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0);
  endtask
  initial begin
    gap[0] = G0;
    gap[1] = G1;
    for (int d = 0; d < 2; d++) begin
      hi_end[d]   = -1;
      busy_end[d] = -1;
      drop_exp[d] = 1'b0;
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    idle(5);
    step(1'b0, 1'b1);
    idle(10);
    step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
    idle(12);
    step(1'b0, 1'b1); idle(5); step(1'b0, 1'b1); step(1'b0, 1'b1);
    idle(10);
    step(1'b0, 1'b1); idle(1); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1);
    idle(8);
    step(1'b0, 1'b1); idle(3); step(1'b0, 1'b1); step(1'b0, 1'b1);
    idle(10);
    step(1'b0, 1'b1); idle(3); step(1'b0, 1'b1);
    idle(10);
    for (int i = 0; i < 600; i++) step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 35);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
